// File: rtl/fifo_sync_buf_pkg.sv
// Shared types for the synchronous FIFO buffer.
// Provides the occupancy-update encoding and the helper that derives it
// from the accepted write/read pair of a cycle.
package fifo_sync_buf_pkg;

  // Occupancy change applied in one cycle
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // Simultaneous accepted write and read cancel out
  function automatic cnt_op_e cnt_op(input logic wr_acc, input logic rd_acc);
    cnt_op_e op;
    case ({wr_acc, rd_acc})
      2'b10:   op = CNT_INC;
      2'b01:   op = CNT_DEC;
      default: op = CNT_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports:
//   clk_i    clock
//   rst_ni   async active-low reset (read register only, array is not reset)
//   we_i     write enable, waddr_i / wdata_i write address / data
//   re_i     read enable, raddr_i read address
//   rdata_o  registered read data, holds while re_i is low
module fifo_dp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_buf.sv
// Single-clock synchronous FIFO buffer with occupancy flags and sticky
// overflow/underflow errors.
// Ports:
//   iClk, iRst_N              clock, async active-low reset
//   iWr_En, iWr_Data          write request / data
//   iRd_En                    read request
//   iClr_Err                  clears sticky error flags (set wins)
//   oRd_Data, oRd_Valid       registered read data, valid one cycle after iRd_En
//   oEmpty, oFull             count == 0 / count == DEPTH
//   oAlmost_Empty/_Full       count <= AE_LEVEL / count >= AF_LEVEL
//   oCount                    occupancy 0..DEPTH
//   oOverflow, oUnderflow     sticky write-while-full / read-while-empty
module fifo_sync_buf
  import fifo_sync_buf_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic              iClk,
  input  logic              iRst_N,
  input  logic              iWr_En,
  input  logic [DATA_W-1:0] iWr_Data,
  input  logic              iRd_En,
  input  logic              iClr_Err,
  output logic [DATA_W-1:0] oRd_Data,
  output logic              oRd_Valid,
  output logic              oEmpty,
  output logic              oFull,
  output logic              oAlmost_Empty,
  output logic              oAlmost_Full,
  output logic [ADDR_W:0]   oCount,
  output logic              oOverflow,
  output logic              oUnderflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("fifo_sync_buf: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ae_q, ae_d;
  logic              af_q, af_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic              uvf_q, uvf_d;
  logic              wr_acc, rd_acc;

  // Acceptance is gated by the registered flags only
  assign wr_acc = iWr_En & ~full_q;
  assign rd_acc = iRd_En & ~empty_q;

  // Next-state: pointers, occupancy, flags from next count, sticky errors
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_acc;

    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    unique case (cnt_op(wr_acc, rd_acc))
      CNT_INC: count_d = count_q + CNT_W'(1);
      CNT_DEC: count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
    ae_d    = (count_d <= CNT_AE);
    af_d    = (count_d >= CNT_AF);

    // Set has priority over clear
    ovf_d = (iWr_En & full_q)  | (ovf_q & ~iClr_Err);
    uvf_d = (iRd_En & empty_q) | (uvf_q & ~iClr_Err);
  end

  // State registers
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ae_q       <= 1'b1;
      af_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      uvf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ae_q       <= ae_d;
      af_q       <= af_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      uvf_q      <= uvf_d;
    end
  end

  // Read data register lives in the RAM read port and holds between reads
  fifo_dp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (iClk),
    .rst_ni  (iRst_N),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (iWr_Data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (oRd_Data)
  );

  assign oRd_Valid     = rd_valid_q;
  assign oEmpty        = empty_q;
  assign oFull         = full_q;
  assign oAlmost_Empty = ae_q;
  assign oAlmost_Full  = af_q;
  assign oCount        = count_q;
  assign oOverflow     = ovf_q;
  assign oUnderflow    = uvf_q;

endmodule

// File: tb/tb_fifo_sync_buf.sv
// Directed bench for fifo_sync_buf with a reference occupancy model and a
// read-data scoreboard.
module tb_fifo_sync_buf;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid, empty, full, a_empty, a_full, ovf, uvf;
  logic [4:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  logic [15:0] m_fifo [$];
  logic [15:0] exp_q  [$];
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;
  logic        m_uvf = 1'b0;
  logic [15:0] m_last = '0;

  fifo_sync_buf dut (
    .iClk          (clk),
    .iRst_N        (rst_n),
    .iWr_En        (wr_en),
    .iWr_Data      (wr_data),
    .iRd_En        (rd_en),
    .iClr_Err      (clr_err),
    .oRd_Data      (rd_data),
    .oRd_Valid     (rd_valid),
    .oEmpty        (empty),
    .oFull         (full),
    .oAlmost_Empty (a_empty),
    .oAlmost_Full  (a_full),
    .oCount        (count),
    .oOverflow     (ovf),
    .oUnderflow    (uvf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".count"},  32'(count),   32'(m_cnt));
    check({tag, ".empty"},  32'(empty),   32'(m_cnt == 0));
    check({tag, ".full"},   32'(full),    32'(m_cnt == DEPTH));
    check({tag, ".aempty"}, 32'(a_empty), 32'(m_cnt <= AE));
    check({tag, ".afull"},  32'(a_full),  32'(m_cnt >= AF));
    check({tag, ".ovf"},    32'(ovf),     32'(m_ovf));
    check({tag, ".uvf"},    32'(uvf),     32'(m_uvf));
  endtask

  // One clock of stimulus; model updated from pre-edge state, outputs checked #1 after edge
  task automatic step(input logic wr, input logic [15:0] wd, input logic rd, input logic clr,
                      input string tag);
    logic wacc, racc;
    wr_en = wr; wr_data = wd; rd_en = rd; clr_err = clr;
    wacc  = wr && (m_cnt != DEPTH);
    racc  = rd && (m_cnt != 0);
    m_ovf = (wr && (m_cnt == DEPTH)) || (m_ovf && !clr);
    m_uvf = (rd && (m_cnt == 0)) || (m_uvf && !clr);
    if (racc) exp_q.push_back(m_fifo.pop_front());
    if (wacc) m_fifo.push_back(wd);
    m_cnt = m_fifo.size();
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    check({tag, ".valid"}, 32'(rd_valid), 32'(racc));
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check({tag, ".unexpected_read"}, 32'(rd_data), 32'hFFFF_FFFF);
      end else begin
        m_last = exp_q.pop_front();
        check({tag, ".data"}, 32'(rd_data), 32'(m_last));
      end
    end else begin
      check({tag, ".hold"}, 32'(rd_data), 32'(m_last));
    end
    check_flags(tag);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst.valid", 32'(rd_valid), 32'd0);
    check("rst.data",  32'(rd_data),  32'd0);
    check_flags("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: fill with 0x0001..0x0010
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0, "fill");
    // 2: drain in order
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 1'b1, 1'b0, "drain");

    // 3: write+read at full -> write rejected, overflow sticky until cleared
    for (int i = 1; i <= 16; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, "fill2");
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, "full_wr_rd");
    step(1'b0, 16'h0, 1'b0, 1'b0, "ovf_hold");
    step(1'b0, 16'h0, 1'b0, 1'b1, "ovf_clr");
    for (int i = 0; i < 15; i++) step(1'b0, 16'h0, 1'b1, 1'b0, "drain2");

    // 4: pointer wrap-around
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 16'h00A0 + 16'(i + 10 * r), 1'b0, 1'b0, "wrap_wr");
      for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1, 1'b0, "wrap_rd");
    end

    // 5: write+read at empty -> underflow, no bypass
    step(1'b1, 16'h1234, 1'b1, 1'b0, "empty_wr_rd");
    step(1'b0, 16'h0, 1'b1, 1'b0, "empty_rd_next");
    step(1'b0, 16'h0, 1'b0, 1'b1, "uvf_clr");

    // 6: async reset mid-operation, with a read just completed
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0, "pre_rst_wr");
    step(1'b0, 16'h0, 1'b1, 1'b0, "pre_rst_rd");
    #2;
    rst_n = 1'b0;
    #1;
    m_fifo.delete(); exp_q.delete();
    m_cnt = 0; m_ovf = 1'b0; m_uvf = 1'b0; m_last = '0;
    check("arst.valid", 32'(rd_valid), 32'd0);
    check("arst.data",  32'(rd_data),  32'd0);
    check_flags("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h5A5A, 1'b0, 1'b0, "post_rst_wr");
    step(1'b0, 16'h0, 1'b1, 1'b0, "post_rst_rd");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
